vote_rx: RTL and testbench

Oversampled serial receiver that sits directly upstream of the three-input majority voter. It takes three samples around the centre of each bit of a noisy asynchronous serial line and votes them to one bit through the voter. It then assembles start/data/stop framing into a parallel word with a one-cycle valid pulse. Single-sample glitches are rejected on every bit, including the start and stop bits.

---
 rtl/vote_rx_pkg.sv | 17 +
 rtl/majority3.sv | 9 +
 rtl/vote_rx.sv | 141 ++++++++++++++
 tb/tb_vote_rx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vote_rx_pkg.sv
// Shared definitions for the oversampled majority-vote serial receiver.
package vote_rx_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int OSR_DEF       = 8;
  localparam int DATA_BITS_DEF = 8;

  // Centre tick of a bit period; samples are taken at mid-1, mid, mid+1.
  function automatic int mid_point(input int osr);
    return osr / 2;
  endfunction

endpackage

// File: rtl/majority3.sv
// Three-input majority voter.
module majority3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic f
);
  assign f = (a & b) | (b & c) | (a & c);
endmodule

// File: rtl/vote_rx.sv
// Oversampled serial receiver: three samples around each bit centre are voted
// to one bit, then start/data/stop framing is assembled into a parallel word.
module vote_rx
  import vote_rx_pkg::*;
#(
  parameter int OSR       = OSR_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  input  logic                 sample_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int M  = mid_point(OSR);
  localparam int TW = $clog2(OSR);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_VOTE = TW'(M + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  logic [1:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 vote;
  logic [DATA_BITS:0]   sh_tmp;

  // The third sample is the live synchronized line, so the vote is only
  // meaningful on the strobe at tick mid+1.
  majority3 u_vote (
    .a (s0_q),
    .b (s1_q),
    .c (rx_s_q),
    .f (vote)
  );

  assign sh_tmp = {vote, shreg_q};

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    if (sample_en) begin
      if (tick_q == T_S0) s0_d = rx_s_q;
      if (tick_q == T_S1) s1_d = rx_s_q;
      case (state_q)
        IDLE: begin
          tick_d = '0;
          if (!rx_s_q) begin
            state_d = START;
            tick_d  = TW'(1);
          end
        end
        START: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == T_VOTE && vote) begin
            state_d = IDLE;
            tick_d  = '0;
          end else if (tick_q == T_LAST) begin
            tick_d    = '0;
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
        DATA: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == T_VOTE) shreg_d = sh_tmp[DATA_BITS:1];
          if (tick_q == T_LAST) begin
            tick_d = '0;
            if (bit_cnt_q == B_LAST) state_d = STOP;
            else                     bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        default: begin
          tick_d = tick_q + TW'(1);
          // Leave at mid-stop so a start edge in its second half is caught.
          if (tick_q == T_VOTE) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            ferr_d  = ~vote;
            state_d = IDLE;
            tick_d  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_in;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_vote_rx.sv
// Directed bench for vote_rx: framing, glitch rejection, false start, bad stop,
// back-to-back frames with sparse strobes, and reset mid-frame.
module tb_vote_rx;
  localparam int OSR = 8;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic          sample_en = 1'b0;
  logic [DB-1:0] data_out;
  logic          data_valid, frame_err, busy;

  int checks = 0, errors = 0;
  int div = 1;
  int nvalid = 0, ferr_stray = 0;
  int n0, c0;
  logic [DB:0] caps[$];

  always #5 clk = ~clk;

  vote_rx #(.OSR(OSR), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .sample_en  (sample_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Each completed frame is captured as {frame_err, data_out}.
  always @(negedge clk) begin
    if (data_valid) begin
      nvalid++;
      caps.push_back({frame_err, data_out});
    end else if (frame_err) begin
      ferr_stray++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One strobe period with rx_in held at v.
  task automatic slot(input bit v);
    rx_in = v;
    if (div > 1) begin
      sample_en = 1'b0;
      repeat (div - 1) @(posedge clk);
      #1;
    end
    sample_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) slot(1'b1);
  endtask

  // gbit: 0 start, 1..DB data, DB+1 stop; -1 for no glitch.
  task automatic send(input logic [DB-1:0] d, input bit stop, input int gbit, input int gtick);
    bit v;
    for (int b = 0; b < DB + 2; b++) begin
      if (b == 0)           v = 1'b0;
      else if (b == DB + 1) v = stop;
      else                  v = d[b-1];
      for (int t = 0; t < OSR; t++) slot(v ^ ((b == gbit) && (t == gtick)));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    idle(4);

    // Clean frame; with a 2-strobe synchronizer lag the pulse lands on the
    // last stop slot.
    n0 = nvalid;
    send(8'hA5, 1'b1, -1, 0);
    chk("clean_valid", 32'(data_valid), 32'h1);
    chk("clean_data", 32'(data_out), 32'hA5);
    chk("clean_ferr", 32'(frame_err), 32'h0);
    slot(1'b1);
    chk("clean_pulse_len", 32'(data_valid), 32'h0);
    idle(4);
    chk("clean_busy", 32'(busy), 32'h0);
    chk("clean_count", 32'(nvalid - n0), 32'h1);

    // Single-strobe glitches at tick mid on data bit 2, stop bit, start bit.
    send(8'h3C, 1'b1, 3, 4);
    idle(4);
    chk("glitch_data", 32'(caps[$]), {23'h0, 1'b0, 8'h3C});
    n0 = nvalid;
    send(8'h3C, 1'b1, DB + 1, 4);
    idle(4);
    chk("glitch_stop_cnt", 32'(nvalid - n0), 32'h1);
    chk("glitch_stop", 32'(caps[$]), {23'h0, 1'b0, 8'h3C});
    send(8'hC3, 1'b1, 0, 4);
    idle(4);
    chk("glitch_start", 32'(caps[$]), {23'h0, 1'b0, 8'hC3});

    // False start: two low strobes; busy drops at start tick mid+1.
    n0 = nvalid;
    slot(1'b0);
    slot(1'b0);
    repeat (5) slot(1'b1);
    chk("false_busy_hi", 32'(busy), 32'h1);
    slot(1'b1);
    chk("false_busy_lo", 32'(busy), 32'h0);
    idle(20);
    chk("false_novalid", 32'(nvalid - n0), 32'h0);

    // Bad stop bit; the low line then re-triggers START.
    send(8'h81, 1'b0, -1, 0);
    chk("bad_valid", 32'(data_valid), 32'h1);
    chk("bad_data", 32'(data_out), 32'h81);
    chk("bad_ferr", 32'(frame_err), 32'h1);
    slot(1'b1);
    chk("break_restart", 32'(busy), 32'h1);
    idle(16);
    chk("bad_busy", 32'(busy), 32'h0);

    // Back-to-back frames, strobe every 3rd clk.
    div = 3;
    idle(4);
    c0 = caps.size();
    send(8'h00, 1'b1, -1, 0);
    send(8'hFF, 1'b1, -1, 0);
    idle(4);
    chk("b2b_count", 32'(caps.size() - c0), 32'h2);
    if (caps.size() >= c0 + 2) begin
      chk("b2b_first", 32'(caps[c0]), {23'h0, 1'b0, 8'h00});
      chk("b2b_second", 32'(caps[c0+1]), {23'h0, 1'b0, 8'hFF});
    end

    // Reset during data bit 4, then a fresh frame.
    div = 1;
    n0 = nvalid;
    repeat (8) slot(1'b0);
    repeat (DB / 2 * OSR + 4) slot(1'b0);
    rx_in = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mid_rst_data", 32'(data_out), 32'h0);
    chk("mid_rst_valid", 32'(data_valid), 32'h0);
    chk("mid_rst_ferr", 32'(frame_err), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    idle(20);
    chk("mid_rst_nopulse", 32'(nvalid - n0), 32'h0);
    send(8'h5A, 1'b1, -1, 0);
    idle(4);
    chk("after_rst_cnt", 32'(nvalid - n0), 32'h1);
    chk("after_rst_data", 32'(caps[$]), {23'h0, 1'b0, 8'h5A});

    chk("ferr_without_valid", 32'(ferr_stray), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
